sample_fifo_apb: RTL and testbench
==================================

# sample_fifo_apb

Sample buffer between the measurement controller and the APB bus. Captures each ADC conversion result when the controller has write enabled and the ADC signals completion. Returns `full` to the controller and exposes the buffered samples plus status, control and threshold registers to the processor over a zero-wait-state APB slave. Raises a level interrupt when the fill level reaches a programmable threshold.

## Interface
Parameters:
- `DATA_W`, 12: sample width in bits, 1..32.
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries (default 16).

Ports (reset is `rst`, asynchronous, active-high; clock is `clk`):
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous active-high reset.
- `wr_en`, in, 1: write enable from the measurement controller.
- `sample_valid`, in, 1: one-cycle ADC done strobe.
- `sample_data`, in, DATA_W: ADC result, valid with `sample_valid`.
- `full`, out, 1: count == DEPTH, registered.
- `empty`, out, 1: count == 0, registered.
- `psel`, `penable`, `pwrite`, in, 1 each: APB control.
- `paddr`, in, 4: byte address; bits [3:2] are decoded.
- `pwdata`, in, 32: APB write data.
- `prdata`, out, 32: APB read data.
- `pready`, out, 1: tied to 1.
- `pslverr`, out, 1: error response.
- `irq`, out, 1: threshold interrupt, registered.

## Operation
Register map (word offsets):
- 0x0 DATA, read-only. The access phase returns the head sample zero-extended to 32 bits and pops it. If empty, returns 0 with `pslverr`=1 and no pop.
- 0x4 STATUS. Read: [0] empty, [1] full, [2] overflow (sticky), [8+:DEPTH_LOG2+1] count. Writing 1 to bit 2 clears overflow.
- 0x8 CTRL, R/W. [0] flush: write-1, self-clearing, reads 0. [1] irq_en, reset 0.
- 0xC THRESH, R/W, [DEPTH_LOG2:0], reset 0. Values above DEPTH are stored as written but never match.
- Writes to DATA are ignored and answered with `pslverr`=1. All other accesses complete with `pslverr`=0.

Datapath and control:
- An APB access is `psel & penable`. `prdata` and `pslverr` are combinational during the access phase and 0 otherwise.
- Storage is a 2^DEPTH_LOG2 × DATA_W array. Read and write pointers are DEPTH_LOG2 bits wide and wrap modulo depth. `count` is DEPTH_LOG2+1 bits.
- Push condition: `sample_valid & wr_en & (!full | pop)`. A push writes `sample_data` at the write pointer and increments it.
- Drop condition: `sample_valid & wr_en & full & !pop`. The sample is discarded and overflow is set. Count and pointers are unchanged.
- `sample_valid` with `wr_en`=0 is ignored and does not set overflow.
- Pop condition: a DATA read access while `!empty`. The read pointer increments.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the push is accepted because of the pop.
  - When empty, the pop is refused (error response) and the push proceeds.
- Flush (CTRL[0] written with 1):
  - On that edge, pointers, count and overflow clear.
  - Flush overrides any simultaneous push or pop.
  - irq_en and THRESH take the written or held values.
- `irq` next value = irq_en & (THRESH != 0) & (count_next >= THRESH).
- Reset values: pointers 0, count 0, `empty`=1, `full`=0, overflow 0, irq_en 0, THRESH 0, `irq`=0, `prdata`=0, `pslverr`=0, `pready`=1. Array contents are undefined.
- Reset mid-operation discards all contents. An APB transfer in flight returns the reset values.

## Timing
- Push, pop, flush and register writes all take effect on the rising `clk` edge of the qualifying cycle.
- `full`, `empty`, count and `irq` reflect the new state from that edge onward, so the registered latency is 1 cycle.
- The data read in the access phase is the pre-pop head; the next read returns the following entry.
- A sample pushed on edge N is readable by an access phase in cycle N+1.
- The controller samples `full` one cycle after `sample_valid`, so it sees the post-push state.
- APB timing: zero wait states, setup phase then access phase, with no back-to-back restriction.

## Test plan
- Reset, then read STATUS. Required: empty=1, full=0, count=0, `irq`=0, `pready`=1.
- Push 16 samples 0x000..0x00F with `wr_en`=1. Required: `full`=1 one cycle after the 16th push. A 17th sample 0xABC is dropped and STATUS overflow=1. Then 16 DATA reads return 0x000..0x00F in order, and empty=1 afterwards.
- Wrap-around: push 10, pop 10, push 12. Required: reads return the 12 new values in order and count passes through 12.
- While full, a DATA read and a push of 0x555 in the same cycle. Required: count stays 16, `full` stays 1, and 0x555 is returned last.
- THRESH=4, irq_en=1. Push 3: `irq`=0. On the 4th push, `irq`=1 on the next cycle. One DATA read makes `irq`=0.
- Empty-read and DATA-write both give `pslverr`=1 with `prdata`=0. Flush while count=7 gives count 0 and overflow 0. A DATA read asserting `rst` mid-access is reset-safe: all outputs return to their reset values.

Source files
------------

// File: rtl/sample_fifo_apb.sv
`default_nettype none
// ============================================================================
// Module   : sample_fifo_apb
// Purpose  : ADC sample FIFO with a zero-wait-state APB slave exposing the
//            buffered samples plus status, control and threshold registers,
//            and a level interrupt on a programmable fill threshold.
// Revision : 1.0 - initial release
// ============================================================================
module sample_fifo_apb #(
  parameter int DATA_W     = 12,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              full,
  output logic              empty,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [3:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         c_DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0]         c_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]     r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_ovf;
  logic                  r_irq_en;
  logic [CW-1:0]         r_thresh;
  logic                  r_irq;

  logic                  w_access;
  logic [1:0]            w_sel;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_flush;
  logic                  w_ovf_clr;
  logic                  w_irq_en_next;
  logic [CW-1:0]         w_thresh_next;
  logic [CW-1:0]         w_count_next;
  logic [31:0]           w_head;
  logic [31:0]           w_status;
  logic                  w_unused;

  // A transfer is cut off while reset is held so the bus sees reset values.
  assign w_access  = psel & penable & ~rst;
  assign w_sel     = paddr[3:2];
  assign w_pop     = w_access & ~pwrite & (w_sel == 2'd0) & ~r_empty;
  assign w_push    = sample_valid & wr_en & (~r_full | w_pop);
  assign w_drop    = sample_valid & wr_en & r_full & ~w_pop;
  assign w_flush   = w_access & pwrite & (w_sel == 2'd2) & pwdata[0];
  assign w_ovf_clr = w_access & pwrite & (w_sel == 2'd1) & pwdata[2];

  assign w_irq_en_next = (w_access & pwrite & (w_sel == 2'd2)) ? pwdata[1] : r_irq_en;
  assign w_thresh_next = (w_access & pwrite & (w_sel == 2'd3)) ? pwdata[CW-1:0] : r_thresh;

  assign w_unused = &{1'b0, paddr[1:0], pwdata};

  // Fill level after this edge; flush wins over any push or pop.
  always_comb begin
    w_count_next = r_count;
    if (w_flush)
      w_count_next = '0;
    else if (w_push && !w_pop)
      w_count_next = r_count + c_CNT_ONE;
    else if (w_pop && !w_push)
      w_count_next = r_count - c_CNT_ONE;
  end

  // Zero-extended head sample and the packed status word.
  always_comb begin
    w_head                 = '0;
    w_head[DATA_W-1:0]     = r_mem[r_rptr];
    w_status               = '0;
    w_status[0]            = r_empty;
    w_status[1]            = r_full;
    w_status[2]            = r_ovf;
    w_status[8 +: CW]      = r_count;
  end

  // Read mux and error response, driven only during a read/write access.
  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (w_access) begin
      pslverr = (w_sel == 2'd0) & (pwrite | r_empty);
      if (!pwrite) begin
        case (w_sel)
          2'd0:    prdata = r_empty ? 32'd0 : w_head;
          2'd1:    prdata = w_status;
          2'd2:    prdata[1] = r_irq_en;
          default: prdata[CW-1:0] = r_thresh;
        endcase
      end
    end
  end

  // Sample storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_push && !w_flush)
      r_mem[r_wptr] <= sample_data;
  end

  // Pointers, level, flags, control registers and the interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
      r_thresh <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
        if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
        // A drop in the same cycle as a clear keeps the event visible.
        if (w_drop)
          r_ovf <= 1'b1;
        else if (w_ovf_clr)
          r_ovf <= 1'b0;
      end
      r_count  <= w_count_next;
      r_full   <= (w_count_next == c_DEPTH);
      r_empty  <= (w_count_next == '0);
      r_irq_en <= w_irq_en_next;
      r_thresh <= w_thresh_next;
      r_irq    <= w_irq_en_next & (w_thresh_next != '0) & (w_count_next >= w_thresh_next);
    end
  end

  assign full  = r_full;
  assign empty = r_empty;
  assign irq   = r_irq;
  assign pready = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sample_fifo_apb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_fifo_apb
// Purpose  : Self-checking bench for sample_fifo_apb using a queue scoreboard
//            of expected FIFO contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_fifo_apb;

  localparam int DATA_W     = 12;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              full;
  logic              empty;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [3:0]        paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic              irq;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] sb_q[$];
  logic              m_ovf;

  sample_fifo_apb #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .sample_valid(sample_valid),
    .sample_data(sample_data), .full(full), .empty(empty),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Drive one sample; the scoreboard keeps it unless the FIFO was full.
  task automatic push_sample(input logic [DATA_W-1:0] d);
    @(negedge clk);
    sample_valid = 1'b1; wr_en = 1'b1; sample_data = d;
    if (sb_q.size() < DEPTH) sb_q.push_back(d);
    else m_ovf = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic e);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1; d = prdata; e = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] v, output logic [31:0] d,
                           output logic e);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = v;
    @(negedge clk);
    penable = 1'b1;
    #1; d = prdata; e = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Read n DATA entries and compare against the scoreboard head.
  task automatic drain(input int n, input string tag);
    logic [31:0] d; logic e; logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = (sb_q.size() > 0) ? {20'd0, sb_q.pop_front()} : 32'd0;
      apb_read(4'h0, d, e);
      checks++;
      if (d !== exp || e !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d]: got data=%h err=%b, expected data=%h err=0", tag, i, d, e, exp);
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] d; logic e;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || irq !== 1'b0 || pready !== 1'b1 ||
        prdata !== 32'd0 || pslverr !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got empty=%b full=%b irq=%b pready=%b, expected 1 0 0 1",
               empty, full, irq, pready);
    end
    rst = 1'b0;
    apb_read(4'h4, d, e);
    checks++;
    if (d !== 32'h0000_0001 || e !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got %h, expected 00000001", d);
    end
  endtask

  task automatic test_fill_overflow;
    logic [31:0] d; logic e;
    for (int i = 0; i < DEPTH; i++) begin
      push_sample(DATA_W'(i));
      if (i == DEPTH - 2) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL full_early: got full=%b after 15 pushes, expected 0", full);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL full_after_16: got full=%b empty=%b, expected 1 0", full, empty);
    end
    push_sample(12'hABC);
    apb_read(4'h4, d, e);
    checks++;
    if (d !== 32'h0000_1006) begin
      errors++;
      $display("FAIL overflow_status: got %h, expected 00001006", d);
    end
    drain(DEPTH, "fill_read");
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL empty_after_drain: got empty=%b full=%b, expected 1 0", empty, full);
    end
    // Clear the sticky overflow so later status reads start clean.
    apb_write(4'h4, 32'h4, d, e);
    m_ovf = 1'b0;
    apb_read(4'h4, d, e);
    checks++;
    if (d[2] !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got ovf=%b, expected 0", d[2]);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] d; logic e;
    for (int i = 0; i < 10; i++) push_sample(DATA_W'(12'h100 + i));
    drain(10, "wrap_first");
    for (int i = 0; i < 12; i++) push_sample(DATA_W'(12'h200 + 7 * i));
    apb_read(4'h4, d, e);
    checks++;
    if (d[12:8] !== 5'd12) begin
      errors++;
      $display("FAIL wrap_count: got %0d, expected 12", d[12:8]);
    end
    drain(12, "wrap_second");
  endtask

  task automatic test_full_simul;
    logic [31:0] d; logic e; logic [31:0] exp;
    for (int i = 0; i < DEPTH; i++) push_sample(DATA_W'(12'h300 + i));
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
    @(negedge clk);
    penable = 1'b1; sample_valid = 1'b1; wr_en = 1'b1; sample_data = 12'h555;
    exp = {20'd0, sb_q.pop_front()};
    sb_q.push_back(12'h555);
    #1; d = prdata;
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL simul_read: got %h, expected %h", d, exp);
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; sample_valid = 1'b0;
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL simul_full: got full=%b, expected 1", full);
    end
    apb_read(4'h4, d, e);
    checks++;
    if (d !== 32'h0000_1002) begin
      errors++;
      $display("FAIL simul_status: got %h, expected 00001002", d);
    end
    drain(DEPTH, "simul_drain");
  endtask

  task automatic test_irq;
    logic [31:0] d; logic e;
    apb_write(4'hC, 32'd4, d, e);
    apb_write(4'h8, 32'h2, d, e);
    for (int i = 0; i < 3; i++) push_sample(DATA_W'(12'h400 + i));
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_below: got irq=%b at count 3, expected 0", irq);
    end
    push_sample(12'h403);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_at_thresh: got irq=%b at count 4, expected 1", irq);
    end
    drain(1, "irq_pop");
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_pop: got irq=%b at count 3, expected 0", irq);
    end
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL ctrl_readback: got %h, expected 00000002", d);
    end
    drain(3, "irq_drain");
  endtask

  task automatic test_errors_flush;
    logic [31:0] d; logic e;
    apb_read(4'h0, d, e);
    checks++;
    if (d !== 32'd0 || e !== 1'b1) begin
      errors++;
      $display("FAIL empty_read: got data=%h err=%b, expected 0 1", d, e);
    end
    apb_write(4'h0, 32'hFFFF_FFFF, d, e);
    checks++;
    if (d !== 32'd0 || e !== 1'b1) begin
      errors++;
      $display("FAIL data_write: got data=%h err=%b, expected 0 1", d, e);
    end
    for (int i = 0; i < DEPTH + 1; i++) push_sample(DATA_W'(12'h600 + i));
    drain(9, "pre_flush");
    apb_read(4'h4, d, e);
    checks++;
    if (d !== 32'h0000_0704) begin
      errors++;
      $display("FAIL pre_flush_status: got %h, expected 00000704", d);
    end
    apb_write(4'h8, 32'h1, d, e);
    sb_q.delete();
    m_ovf = 1'b0;
    apb_read(4'h4, d, e);
    checks++;
    if (d !== 32'h0000_0001 || irq !== 1'b0) begin
      errors++;
      $display("FAIL flush_status: got %h irq=%b, expected 00000001 irq=0", d, irq);
    end
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL flush_selfclear: got %h, expected 00000000", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic e;
    apb_write(4'hC, 32'd2, d, e);
    apb_write(4'h8, 32'h2, d, e);
    for (int i = 0; i < 5; i++) push_sample(DATA_W'(12'h700 + i));
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
    @(negedge clk);
    penable = 1'b1;
    #1; d = prdata;
    checks++;
    if (d !== 32'h700 || irq !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read: got %h irq=%b, expected 00000700 irq=1", d, irq);
    end
    #1; rst = 1'b1;
    #1;
    sb_q.delete();
    checks++;
    if (prdata !== 32'd0 || pslverr !== 1'b0 || full !== 1'b0 || empty !== 1'b1 ||
        irq !== 1'b0 || pready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got prdata=%h err=%b full=%b empty=%b irq=%b pready=%b",
               prdata, pslverr, full, empty, irq, pready);
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    apb_read(4'h4, d, e);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++;
      $display("FAIL post_reset_status: got %h, expected 00000001", d);
    end
    apb_read(4'hC, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_thresh: got %h, expected 00000000", d);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; sample_valid = 1'b0; sample_data = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    m_ovf = 1'b0;
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_full_simul();
    test_irq();
    test_errors_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
